kt8_io: RTL and testbench

- Data-bus decoder and memory-mapped I/O block for the KT8 data address space.
- Sits between the CPU data port and the 16-byte data RAM.
- Address bit 4 selects: 0x00-0x0F go to RAM, 0x10-0x1F go to the I/O registers in this block.
- Provides GPIO, an 8-bit compare timer, and a transmit byte FIFO with a valid/ready output stream.

---
 rtl/kt8_io_pkg.sv | 45 ++++
 rtl/kt8_io_fifo.sv | 72 +++++++
 rtl/kt8_io.sv | 246 ++++++++++++++++++++++++
 tb/tb_kt8_io.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kt8_io_pkg.sv
// ============================================================================
// Module      : kt8_io_pkg
// Description : Shared definitions for the KT8 data-bus decoder and I/O block:
//               I/O region select bit, register offsets, TMR_CTRL and STATUS
//               bit positions, and the prescaler-select clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kt8_io_pkg;

    // Address bit that steers an access to the I/O registers instead of RAM
    localparam int IO_SEL_BIT = 4;

    // Register offsets within the I/O region (address[3:0])
    localparam logic [3:0] OFF_GPIO_OUT = 4'h0;
    localparam logic [3:0] OFF_GPIO_IN  = 4'h1;
    localparam logic [3:0] OFF_TMR_CNT  = 4'h2;
    localparam logic [3:0] OFF_TMR_CMP  = 4'h3;
    localparam logic [3:0] OFF_TMR_CTRL = 4'h4;
    localparam logic [3:0] OFF_STATUS   = 4'h5;
    localparam logic [3:0] OFF_TX_DATA  = 4'h6;

    // TMR_CTRL bit positions
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_PS_LSB  = 1;
    localparam int CTRL_PS_MSB  = 3;
    localparam int CTRL_IRQ_BIT = 4;

    // STATUS bit positions
    localparam int STAT_MATCH_BIT = 0;
    localparam int STAT_OVR_BIT   = 1;
    localparam int STAT_FULL_BIT  = 2;
    localparam int STAT_EMPTY_BIT = 3;

    // Prescale shift actually used: the select is clamped to the counter width
    function automatic int eff_prescale(input logic [2:0] sel, input int pw);
        int s;
        s = int'(sel);
        return (s < pw) ? s : pw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/kt8_io_fifo.sv
// ============================================================================
// Module      : kt8_io_fifo
// Description : Transmit byte FIFO for the KT8 I/O block. Pushes into a full
//               FIFO and pops from an empty FIFO are ignored; the head byte
//               reads 0x00 while empty. DEPTH must be a power of two so the
//               pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kt8_io_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_cnt_w'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    // Gate the head so the stream shows 0x00 whenever nothing is queued
    assign head_data = empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents are don't-care until covered by r_count
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push/pop leaves count alone
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/kt8_io.sv
// ============================================================================
// Module      : kt8_io
// Description : KT8 data-bus decoder and memory-mapped I/O block. Address
//               bit 4 splits RAM (0x00-0x0F) from the I/O registers
//               (0x10-0x1F): GPIO, an 8-bit compare timer with prescaler,
//               and a transmit byte FIFO with a valid/ready output stream.
//               Optional macro KT8_IO_IRQ_EN enables the timer interrupt;
//               without it irq_o is tied low and TMR_CTRL bit 4 reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kt8_io
    import kt8_io_pkg::*;
#(
    parameter int TX_DEPTH   = 4,
    parameter int PRESCALE_W = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] cpu_address_i,
    input  logic [7:0] cpu_data_i,
    input  logic       cpu_we_i,
    output logic [7:0] cpu_data_o,
    input  logic [7:0] ram_data_i,
    output logic       ram_we_o,
    input  logic [7:0] gpio_i,
    output logic [7:0] gpio_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       irq_o
);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       w_io_sel;
    logic [3:0] w_off;
    logic       w_io_wr;
    logic       w_wr_gpio, w_wr_cnt, w_wr_cmp, w_wr_ctrl, w_wr_stat, w_wr_tx;

    assign w_io_sel  = cpu_address_i[IO_SEL_BIT];
    assign w_off     = cpu_address_i[3:0];
    assign w_io_wr   = cpu_we_i & w_io_sel;
    assign ram_we_o  = cpu_we_i & ~w_io_sel;

    assign w_wr_gpio = w_io_wr & (w_off == OFF_GPIO_OUT);
    assign w_wr_cnt  = w_io_wr & (w_off == OFF_TMR_CNT);
    assign w_wr_cmp  = w_io_wr & (w_off == OFF_TMR_CMP);
    assign w_wr_ctrl = w_io_wr & (w_off == OFF_TMR_CTRL);
    assign w_wr_stat = w_io_wr & (w_off == OFF_STATUS);
    assign w_wr_tx   = w_io_wr & (w_off == OFF_TX_DATA);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [7:0]            r_gpio_out;
    logic [7:0]            r_sync1, r_sync2;
    logic [7:0]            r_cnt, r_cmp;
    logic                  r_ctrl_en;
    logic [2:0]            r_ctrl_ps;
    logic                  w_ctrl_irq;
    logic [PRESCALE_W-1:0] r_presc;
    logic [PRESCALE_W-1:0] w_presc_term;
    logic                  w_tick;
    logic                  w_match_set;
    logic                  r_match;
    logic                  w_ovr_set;
    logic                  r_ovr;
    logic                  w_fifo_full, w_fifo_empty;
    logic [7:0]            w_fifo_head;
    logic                  w_pop;

    // GPIO output latch and two-flop input synchronizer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_gpio_out <= 8'h00;
            r_sync1    <= 8'h00;
            r_sync2    <= 8'h00;
        end else begin
            if (w_wr_gpio) begin
                r_gpio_out <= cpu_data_i;
            end
            r_sync1 <= gpio_i;
            r_sync2 <= r_sync1;
        end
    end

    assign gpio_o = r_gpio_out;

    // Timer compare value and control fields
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cmp     <= 8'h00;
            r_ctrl_en <= 1'b0;
            r_ctrl_ps <= 3'd0;
        end else begin
            if (w_wr_cmp) begin
                r_cmp <= cpu_data_i;
            end
            if (w_wr_ctrl) begin
                r_ctrl_en <= cpu_data_i[CTRL_EN_BIT];
                r_ctrl_ps <= cpu_data_i[CTRL_PS_MSB:CTRL_PS_LSB];
            end
        end
    end

    // Terminal prescaler count: a tick every 2^min(s, PRESCALE_W) cycles
    always_comb begin
        w_presc_term = PRESCALE_W'((1 << eff_prescale(r_ctrl_ps, PRESCALE_W)) - 1);
    end

    assign w_tick      = r_ctrl_en & (r_presc == w_presc_term);
    // A CPU load of TMR_CNT overrides the tick, so it cannot raise a match
    assign w_match_set = w_tick & ~w_wr_cnt & (r_cnt == r_cmp);

    // Prescaler restarts on any control write and idles at 0 while disabled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_presc <= '0;
        end else if (w_wr_ctrl || !r_ctrl_en || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESCALE_W'(1);
        end
    end

    // Timer counter: CPU load wins, otherwise count up or restart on compare
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= 8'h00;
        end else if (w_wr_cnt) begin
            r_cnt <= cpu_data_i;
        end else if (w_tick) begin
            r_cnt <= (r_cnt == r_cmp) ? 8'h00 : r_cnt + 8'h01;
        end
    end

    assign w_ovr_set = w_wr_tx & w_fifo_full;

    // Sticky status flags; a set in the same cycle as a W1C takes priority
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_match <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_match_set) begin
                r_match <= 1'b1;
            end else if (w_wr_stat && cpu_data_i[STAT_MATCH_BIT]) begin
                r_match <= 1'b0;
            end
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (w_wr_stat && cpu_data_i[STAT_OVR_BIT]) begin
                r_ovr <= 1'b0;
            end
        end
    end

`ifdef KT8_IO_IRQ_EN
    logic r_ctrl_irq;
    logic r_irq;

    // Interrupt enable bit and registered request, one cycle behind match
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl_irq <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl_irq <= cpu_data_i[CTRL_IRQ_BIT];
            end
            r_irq <= r_ctrl_irq & r_match;
        end
    end

    assign w_ctrl_irq = r_ctrl_irq;
    assign irq_o      = r_irq;
`else
    assign w_ctrl_irq = 1'b0;
    assign irq_o      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    assign w_pop = tx_ready_i & ~w_fifo_empty;

    kt8_io_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (w_wr_tx),
        .push_data (cpu_data_i),
        .pop       (w_pop),
        .head_data (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign tx_data_o  = w_fifo_head;
    assign tx_valid_o = ~w_fifo_empty;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [7:0] w_ctrl_rd;
    logic [7:0] w_status_rd;
    logic [7:0] w_io_rdata;

    // Assemble TMR_CTRL and STATUS read views; undefined bits read 0
    always_comb begin
        w_ctrl_rd                          = 8'h00;
        w_ctrl_rd[CTRL_EN_BIT]             = r_ctrl_en;
        w_ctrl_rd[CTRL_PS_MSB:CTRL_PS_LSB] = r_ctrl_ps;
        w_ctrl_rd[CTRL_IRQ_BIT]            = w_ctrl_irq;

        w_status_rd                 = 8'h00;
        w_status_rd[STAT_MATCH_BIT] = r_match;
        w_status_rd[STAT_OVR_BIT]   = r_ovr;
        w_status_rd[STAT_FULL_BIT]  = w_fifo_full;
        w_status_rd[STAT_EMPTY_BIT] = w_fifo_empty;
    end

    // Side-effect-free register read mux; unmapped offsets read 0x00
    always_comb begin
        w_io_rdata = 8'h00;
        case (w_off)
            OFF_GPIO_OUT: w_io_rdata = r_gpio_out;
            OFF_GPIO_IN:  w_io_rdata = r_sync2;
            OFF_TMR_CNT:  w_io_rdata = r_cnt;
            OFF_TMR_CMP:  w_io_rdata = r_cmp;
            OFF_TMR_CTRL: w_io_rdata = w_ctrl_rd;
            OFF_STATUS:   w_io_rdata = w_status_rd;
            default:      w_io_rdata = 8'h00;
        endcase
    end

    assign cpu_data_o = w_io_sel ? w_io_rdata : ram_data_i;

endmodule

`default_nettype wire

// File: tb/tb_kt8_io.sv
// ============================================================================
// Module      : tb_kt8_io
// Description : Self-checking bench for kt8_io: a table of single-cycle bus
//               vectors, hand-written timer/GPIO/reset sequences, and a byte
//               scoreboard for the transmit stream. Expectations follow the
//               KT8_IO_IRQ_EN macro when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kt8_io;

    localparam int TX_DEPTH   = 4;
    localparam int PRESCALE_W = 3;

`ifdef KT8_IO_IRQ_EN
    localparam logic       IRQ_ON     = 1'b1;
    localparam logic [7:0] CTRL_FE_RD = 8'h1E;
    localparam logic [7:0] CTRL_11_RD = 8'h11;
`else
    localparam logic       IRQ_ON     = 1'b0;
    localparam logic [7:0] CTRL_FE_RD = 8'h0E;
    localparam logic [7:0] CTRL_11_RD = 8'h01;
`endif

    logic       clk = 1'b0;
    logic       rst_i;
    logic [4:0] cpu_address_i;
    logic [7:0] cpu_data_i;
    logic       cpu_we_i;
    logic [7:0] cpu_data_o;
    logic [7:0] ram_data_i;
    logic       ram_we_o;
    logic [7:0] gpio_i;
    logic [7:0] gpio_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       irq_o;

    always #5 clk = ~clk;

    kt8_io #(
        .TX_DEPTH   (TX_DEPTH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cpu_address_i (cpu_address_i),
        .cpu_data_i    (cpu_data_i),
        .cpu_we_i      (cpu_we_i),
        .cpu_data_o    (cpu_data_o),
        .ram_data_i    (ram_data_i),
        .ram_we_o      (ram_we_o),
        .gpio_i        (gpio_i),
        .gpio_o        (gpio_o),
        .tx_data_o     (tx_data_o),
        .tx_valid_o    (tx_valid_o),
        .tx_ready_i    (tx_ready_i),
        .irq_o         (irq_o)
    );

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] ram;
        logic       exp_ram_we;
        logic [7:0] exp_rd;
        logic [7:0] exp_gpio;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb_q[$];
    logic [7:0] exp_head;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        cpu_address_i = a;
        cpu_data_i    = d;
        cpu_we_i      = 1'b1;
        tick();
        cpu_we_i      = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [7:0] exp);
        cpu_address_i = a;
        cpu_we_i      = 1'b0;
        #1;
        check(name, cpu_data_o, exp);
    endtask

    // Model push: queued if the model has room, otherwise an expected drop
    task automatic push(input logic [7:0] d);
        if (sb_q.size() < TX_DEPTH) sb_q.push_back(d);
        wr(5'h16, d);
    endtask

    // Drain the stream, comparing each byte against the scoreboard
    task automatic drain(input string name, input int exp_n);
        int n;
        n = 0;
        tx_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!tx_valid_o) break;
            if (sb_q.size() == 0) begin
                check({name, " extra byte"}, tx_valid_o, 1'b0);
                break;
            end
            exp_head = sb_q.pop_front();
            check({name, " data"}, tx_data_o, exp_head);
            n++;
            tick();
        end
        tx_ready_i = 1'b0;
        check({name, " count"}, n, exp_n);
        check({name, " valid low"}, tx_valid_o, 1'b0);
        check({name, " model left"}, sb_q.size(), 0);
    endtask

    // Count cycles until STATUS.match rises (bounded)
    task automatic wait_match(input string name, input int exp_cycles);
        int n;
        n = 0;
        cpu_address_i = 5'h15;
        cpu_we_i      = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (cpu_data_o[0] === 1'b1) begin
                n = i;
                break;
            end
        end
        check(name, n, exp_cycles);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //                    we    addr   wdata  ram    rwe   rd          gpio
        vecs[0]  = '{1'b1, 5'h03, 8'h5A, 8'h00, 1'b1, 8'h00,      8'h00};
        vecs[1]  = '{1'b0, 5'h10, 8'h00, 8'h00, 1'b0, 8'h00,      8'h00};
        vecs[2]  = '{1'b1, 5'h10, 8'hA5, 8'h00, 1'b0, 8'h00,      8'h00};
        vecs[3]  = '{1'b0, 5'h10, 8'h00, 8'h00, 1'b0, 8'hA5,      8'hA5};
        vecs[4]  = '{1'b0, 5'h03, 8'h00, 8'h77, 1'b0, 8'h77,      8'hA5};
        vecs[5]  = '{1'b1, 5'h1F, 8'hFF, 8'h00, 1'b0, 8'h00,      8'hA5};
        vecs[6]  = '{1'b0, 5'h1F, 8'h00, 8'h00, 1'b0, 8'h00,      8'hA5};
        vecs[7]  = '{1'b0, 5'h15, 8'h00, 8'h00, 1'b0, 8'h08,      8'hA5};
        vecs[8]  = '{1'b1, 5'h13, 8'h42, 8'h00, 1'b0, 8'h00,      8'hA5};
        vecs[9]  = '{1'b0, 5'h13, 8'h00, 8'h00, 1'b0, 8'h42,      8'hA5};
        vecs[10] = '{1'b1, 5'h14, 8'hFE, 8'h00, 1'b0, 8'h00,      8'hA5};
        vecs[11] = '{1'b0, 5'h14, 8'h00, 8'h00, 1'b0, CTRL_FE_RD, 8'hA5};
        vecs[12] = '{1'b1, 5'h14, 8'h00, 8'h00, 1'b0, CTRL_FE_RD, 8'hA5};
        vecs[13] = '{1'b0, 5'h16, 8'h00, 8'h00, 1'b0, 8'h00,      8'hA5};
        vecs[14] = '{1'b1, 5'h07, 8'h00, 8'hC9, 1'b1, 8'hC9,      8'hA5};
        vecs[15] = '{1'b1, 5'h12, 8'h9C, 8'h00, 1'b0, 8'h00,      8'hA5};
        vecs[16] = '{1'b0, 5'h12, 8'h00, 8'h00, 1'b0, 8'h9C,      8'hA5};
        vecs[17] = '{1'b0, 5'h11, 8'h00, 8'h00, 1'b0, 8'h00,      8'hA5};

        rst_i         = 1'b1;
        cpu_address_i = 5'h00;
        cpu_data_i    = 8'h00;
        cpu_we_i      = 1'b0;
        ram_data_i    = 8'h00;
        gpio_i        = 8'h00;
        tx_ready_i    = 1'b0;
        tick();
        tick();

        // Reset state, and the RAM strobe stays combinational in reset
        check("rst gpio_o", gpio_o, 8'h00);
        check("rst tx_valid", tx_valid_o, 1'b0);
        check("rst tx_data", tx_data_o, 8'h00);
        check("rst irq", irq_o, 1'b0);
        cpu_address_i = 5'h03;
        cpu_we_i      = 1'b1;
        #1;
        check("rst ram_we comb", ram_we_o, 1'b1);
        cpu_we_i = 1'b0;
        rst_i    = 1'b0;
        tick();

        // Table-driven bus vectors
        for (int i = 0; i < NVEC; i++) begin
            cpu_address_i = vecs[i].addr;
            cpu_data_i    = vecs[i].wdata;
            cpu_we_i      = vecs[i].we;
            ram_data_i    = vecs[i].ram;
            #1;
            check($sformatf("vec%0d rdata", i), cpu_data_o, vecs[i].exp_rd);
            check($sformatf("vec%0d ram_we", i), ram_we_o, vecs[i].exp_ram_we);
            check($sformatf("vec%0d gpio_o", i), gpio_o, vecs[i].exp_gpio);
            tick();
        end
        cpu_we_i   = 1'b0;
        ram_data_i = 8'h00;

        // Timer, s=0: match on 4th tick, counter back to 0
        wr(5'h12, 8'h00);
        wr(5'h13, 8'h03);
        wr(5'h15, 8'h01);
        wr(5'h14, 8'h01);
        wait_match("tmr s0 cycles", 4);
        rd_chk("tmr s0 cnt", 5'h12, 8'h00);
        wr(5'h15, 8'h01);
        rd_chk("match w1c", 5'h15, 8'h08);

        // Timer, s=2: 16 cycles to match
        wr(5'h14, 8'h00);
        wr(5'h12, 8'h00);
        wr(5'h15, 8'h01);
        wr(5'h14, 8'h05);
        wait_match("tmr s2 cycles", 16);
        rd_chk("tmr s2 cnt", 5'h12, 8'h00);

        // Select above the prescaler width clamps; CMP=0 matches on first tick
        wr(5'h14, 8'h00);
        wr(5'h12, 8'h00);
        wr(5'h13, 8'h00);
        wr(5'h15, 8'h01);
        wr(5'h14, 8'h0F);
        wait_match("tmr s7 clamp cycles", 8);

        // CNT write on a tick edge: write wins, no match
        wr(5'h14, 8'h00);
        wr(5'h12, 8'h00);
        wr(5'h15, 8'h01);
        wr(5'h14, 8'h01);
        wr(5'h12, 8'h07);
        rd_chk("cnt write wins", 5'h12, 8'h07);
        rd_chk("no match on cnt write", 5'h15, 8'h08);
        wr(5'h12, 8'h00);
        wr(5'h15, 8'h01);
        rd_chk("set beats w1c", 5'h15, 8'h09);
        wr(5'h14, 8'h00);
        wr(5'h15, 8'h01);
        rd_chk("match cleared", 5'h15, 8'h08);

        // Interrupt path with CTRL=0x11
        wr(5'h12, 8'h00);
        wr(5'h13, 8'h03);
        wr(5'h14, 8'h11);
        wait_match("irq tmr cycles", 4);
        check("irq at match", irq_o, 1'b0);
        tick();
        check("irq one later", irq_o, IRQ_ON);
        rd_chk("ctrl 0x11 read", 5'h14, CTRL_11_RD);
        wr(5'h15, 8'h01);
        check("irq at w1c edge", irq_o, IRQ_ON);
        tick();
        check("irq cleared", irq_o, 1'b0);
        wr(5'h14, 8'h00);
        wr(5'h15, 8'h01);

        // GPIO_IN synchronizer latency
        gpio_i = 8'hC3;
        rd_chk("gpio_in c0", 5'h11, 8'h00);
        tick();
        rd_chk("gpio_in c1", 5'h11, 8'h00);
        tick();
        rd_chk("gpio_in c2", 5'h11, 8'hC3);

        // FIFO fill with overrun
        check("fifo idle valid", tx_valid_o, 1'b0);
        push(8'h11);
        check("valid after push", tx_valid_o, 1'b1);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        push(8'h55);
        rd_chk("full+overrun", 5'h15, 8'h06);
        tick();
        tick();
        check("head stable", tx_data_o, 8'h11);
        drain("fill drain", 4);
        rd_chk("empty after drain", 5'h15, 8'h0A);
        wr(5'h15, 8'h02);
        rd_chk("ovr w1c", 5'h15, 8'h08);

        // Full FIFO: pop and push on the same edge drops the push
        push(8'hA0);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        rd_chk("full no ovr", 5'h15, 8'h04);
        tx_ready_i = 1'b1;
        exp_head   = sb_q.pop_front();
        check("simul head", tx_data_o, exp_head);
        wr(5'h16, 8'h66);
        drain("simul drain", 3);
        rd_chk("simul overrun", 5'h15, 8'h0A);
        wr(5'h15, 8'h02);

        // Push and pop together when partially filled: count unchanged
        push(8'hB0);
        tx_ready_i = 1'b1;
        exp_head   = sb_q.pop_front();
        check("pp head", tx_data_o, exp_head);
        sb_q.push_back(8'hB1);
        wr(5'h16, 8'hB1);
        rd_chk("pp status", 5'h15, 8'h00);
        drain("pp drain", 1);

        // Reset mid-operation
        push(8'hC1);
        push(8'hC2);
        wr(5'h13, 8'h50);
        wr(5'h14, 8'h01);
        tick();
        rst_i = 1'b1;
        tick();
        check("mid rst gpio_o", gpio_o, 8'h00);
        check("mid rst tx_valid", tx_valid_o, 1'b0);
        check("mid rst tx_data", tx_data_o, 8'h00);
        check("mid rst irq", irq_o, 1'b0);
        rd_chk("mid rst cnt", 5'h12, 8'h00);
        rd_chk("mid rst cmp", 5'h13, 8'h00);
        rd_chk("mid rst ctrl", 5'h14, 8'h00);
        rd_chk("mid rst status", 5'h15, 8'h08);
        rd_chk("mid rst gpio_in", 5'h11, 8'h00);
        sb_q.delete();
        rst_i = 1'b0;
        tick();
        check("post rst valid", tx_valid_o, 1'b0);
        rd_chk("post rst cnt idle", 5'h12, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
